// File: rtl/mole_hit_judge.sv
// Player-side judge: debounces 8 buttons, judges hit/miss per lane against the mole vector,
// pulses molehit on hits and keeps saturating score/miss counters. Optional: MISS_PENALTY_EN.
module mole_hit_judge #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCORE_W         = 10,
  parameter int MISS_W          = 8
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               game_active,
  input  logic               clear,
  input  logic [7:0]         mole,
  input  logic [7:0]         btn,
  output logic [7:0]         molehit,
  output logic               hit_any,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;

  // Accumulators are wide enough for counter + 8 hits, plus a sign bit for the penalty case.
  localparam int ACC_W  = ((SCORE_W > 4) ? SCORE_W : 4) + 2;
  localparam int MACC_W = ((MISS_W > 4) ? MISS_W : 4) + 1;
  localparam logic signed [ACC_W-1:0] SCORE_MAX =
    $signed({{(ACC_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}});
  localparam logic [MACC_W-1:0] MISS_MAX = {{(MACC_W-MISS_W){1'b0}}, {MISS_W{1'b1}}};

  logic [7:0]         sync1_q, sync2_q;
  logic [7:0]         deb_q, deb_d, deb_prev_q;
  logic [CNT_W-1:0]   cnt_q [8];
  logic [CNT_W-1:0]   cnt_d [8];
  logic [1:0]         state_q [8];
  logic [1:0]         state_d [8];
  logic [7:0]         press;
  logic [7:0]         hit_vec, miss_vec;
  logic [3:0]         hit_cnt, miss_cnt;
  logic [7:0]         molehit_q;
  logic               hit_any_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic signed [ACC_W-1:0] score_acc;
  logic [MACC_W-1:0]  miss_acc;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  // Debounce: the counter restarts whenever the synced level agrees with the accepted level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // NOTE: every output of this block gets a default before any branch, so no latches form.
  always_comb begin
    hit_vec  = '0;
    miss_vec = '0;
    for (int i = 0; i < 8; i++) begin
      state_d[i] = state_q[i];
      if (clear) begin
        state_d[i] = ST_IDLE;
      end else if (game_active) begin
        case (state_q[i])
          ST_IDLE: begin
            if (press[i])     miss_vec[i] = 1'b1;
            else if (mole[i]) state_d[i]  = ST_UP;
          end
          ST_UP: begin
            if (press[i] && mole[i]) begin
              hit_vec[i] = 1'b1;
              state_d[i] = ST_HIT;
            end else if (!mole[i]) begin
              miss_vec[i] = press[i];
              state_d[i]  = ST_IDLE;
            end
          end
          ST_HIT:  if (!mole[i]) state_d[i] = ST_IDLE;
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    hit_cnt   = popcount8(hit_vec);
    miss_cnt  = popcount8(miss_vec);
    score_acc = $signed({{(ACC_W-SCORE_W){1'b0}}, score_q})
              + $signed({{(ACC_W-4){1'b0}}, hit_cnt});
`ifdef MISS_PENALTY_EN
    score_acc = score_acc - $signed({{(ACC_W-4){1'b0}}, miss_cnt});
`endif
    miss_acc  = {{(MACC_W-MISS_W){1'b0}}, misses_q} + {{(MACC_W-4){1'b0}}, miss_cnt};

    if (clear)                     score_d = '0;
    else if (score_acc[ACC_W-1])   score_d = '0;
    else if (score_acc > SCORE_MAX) score_d = {SCORE_W{1'b1}};
    else                           score_d = score_acc[SCORE_W-1:0];

    if (clear)                     misses_d = '0;
    else if (miss_acc > MISS_MAX)  misses_d = {MISS_W{1'b1}};
    else                           misses_d = miss_acc[MISS_W-1:0];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      molehit_q  <= '0;
      hit_any_q  <= 1'b0;
      score_q    <= '0;
      misses_q   <= '0;
      // NOTE: these per-lane arrays are plain flop banks, not RAM, so they take the reset too.
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      molehit_q  <= hit_vec;
      hit_any_q  <= |hit_vec;
      score_q    <= score_d;
      misses_q   <= misses_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign molehit = molehit_q;
  assign hit_any = hit_any_q;
  assign score   = score_q;
  assign misses  = misses_q;

endmodule
